// File: rtl/g11620_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : g11620_pkg
//  Description : Shared definitions for the G11620 sensor interface: FSM
//                state encoding, video pattern codes, default frame geometry
//                and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package g11620_pkg;

    // Default frame geometry, shared with the G11620 controller
    localparam int unsigned c_PIX_NUM_DEF   = 511;
    localparam int unsigned c_BLANK_CYC_DEF = 24;

    // Sensor emulator state encoding
    localparam int unsigned c_STATE_W  = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_INTEG   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DELAY   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_READOUT = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_BLANK   = 3'd4;

    // Video pattern codes
    localparam logic [1:0] c_PAT_RAMP      = 2'd0;
    localparam logic [1:0] c_PAT_FLAT      = 2'd1;
    localparam logic [1:0] c_PAT_RAMP_FLAT = 2'd2;
    localparam logic [1:0] c_PAT_CHECKER   = 2'd3;

    // Bits needed to hold values 0..max_val (never less than one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/g11620_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : g11620_pattern_gen
//  Description : Combinational video pattern generator. Produces the pixel
//                value for a pixel index from the latched pattern select and
//                the last integration length, saturating to DATA_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module g11620_pattern_gen
    import g11620_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PCNT_W      = 9,
    parameter int unsigned INTEG_SHIFT = 4
) (
    input  logic [PCNT_W-1:0] pcnt,
    input  logic [31:0]       integ,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] pix
);

    // Largest representable sample, held at 33 bits to compare against sums
    localparam logic [32:0] c_MAX = (33'd1 << DATA_W) - 33'd1;

    logic [32:0] w_level;
    logic [32:0] w_sum;

    // 33-bit arithmetic so the ramp+flat sum can never wrap before clamping
    assign w_level = {1'b0, integ >> INTEG_SHIFT};
    assign w_sum   = w_level + 33'(pcnt);

    // Pattern mux with saturation of the intensity-based patterns
    always_comb begin
        pix = '0;
        case (sel)
            c_PAT_RAMP:      pix = DATA_W'(pcnt);
            c_PAT_FLAT:      pix = (w_level > c_MAX) ? '1 : w_level[DATA_W-1:0];
            c_PAT_RAMP_FLAT: pix = (w_sum > c_MAX) ? '1 : w_sum[DATA_W-1:0];
            c_PAT_CHECKER:   pix = pcnt[0] ? '1 : '0;
            default:         pix = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/g11620_sensor_emu.sv
`default_nettype none
// ============================================================================
//  Module      : g11620_sensor_emu
//  Description : Emulator of the G11620 InGaAs linear sensor. Measures the
//                integration length on reset_in, issues the AD start pulse,
//                streams one frame of pattern video with end-of-scan, then
//                blanks. reset_in high outside IDLE/INTEG aborts to INTEG.
//  Revision    : 1.0 - initial release
// ============================================================================
module g11620_sensor_emu
    import g11620_pkg::*;
#(
    parameter int unsigned PIX_NUM     = c_PIX_NUM_DEF,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SP_DELAY    = 4,
    parameter int unsigned BLANK_CYC   = c_BLANK_CYC_DEF,
    parameter int unsigned INTEG_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reset_in,
    input  logic [1:0]        pattern_sel,
    output logic              ad_sp_o,
    output logic [DATA_W-1:0] video_o,
    output logic              video_valid_o,
    output logic              eos_o,
    output logic [31:0]       integ_cnt_o,
    output logic [15:0]       frame_cnt_o,
    output logic              busy_o
);

    localparam int unsigned c_PCNT_W = cnt_width(PIX_NUM);
    localparam int unsigned c_DCNT_W = cnt_width(SP_DELAY - 1);
    localparam int unsigned c_BCNT_W = cnt_width(BLANK_CYC - 1);

    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(PIX_NUM);
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(SP_DELAY - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(BLANK_CYC - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;

    logic [31:0]          r_icnt;
    logic [c_DCNT_W-1:0]  r_dcnt;
    logic [c_PCNT_W-1:0]  r_pcnt;
    logic [c_BCNT_W-1:0]  r_bcnt;
    logic [1:0]           r_sel;

    logic                 r_ad_sp;
    logic [DATA_W-1:0]    r_video;
    logic                 r_valid;
    logic                 r_eos;
    logic [31:0]          r_integ_cnt;
    logic [15:0]          r_frame_cnt;
    logic                 r_busy;

    logic                 w_dly_done;
    logic                 w_pix_last;
    logic                 w_blk_done;
    logic                 w_rd_active;
    logic                 w_ad_sp_nxt;
    logic                 w_valid_nxt;
    logic                 w_eos_nxt;
    logic [DATA_W-1:0]    w_video_nxt;
    logic [DATA_W-1:0]    w_pix;

    assign w_dly_done = (r_dcnt == c_DCNT_LAST);
    assign w_pix_last = (r_pcnt == c_PCNT_LAST);
    assign w_blk_done = (r_bcnt == c_BCNT_LAST);

    g11620_pattern_gen #(
        .DATA_W      (DATA_W),
        .PCNT_W      (c_PCNT_W),
        .INTEG_SHIFT (INTEG_SHIFT)
    ) u_pattern_gen (
        .pcnt  (r_pcnt),
        .integ (r_integ_cnt),
        .sel   (r_sel),
        .pix   (w_pix)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; reset_in in DELAY/READOUT/BLANK overrides everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (reset_in) w_state_nxt = c_ST_INTEG;
            c_ST_INTEG:   if (!reset_in) w_state_nxt = c_ST_DELAY;
            c_ST_DELAY:   if (reset_in) w_state_nxt = c_ST_INTEG;
                          else if (w_dly_done) w_state_nxt = c_ST_READOUT;
            c_ST_READOUT: if (reset_in) w_state_nxt = c_ST_INTEG;
                          else if (w_pix_last) w_state_nxt = c_ST_BLANK;
            c_ST_BLANK:   if (reset_in) w_state_nxt = c_ST_INTEG;
                          else if (w_blk_done) w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from state and inputs
    always_comb begin
        w_rd_active = (r_state == c_ST_READOUT) && !reset_in;
        w_ad_sp_nxt = (r_state == c_ST_DELAY) && !reset_in && w_dly_done;
        w_valid_nxt = w_rd_active;
        w_eos_nxt   = w_rd_active && w_pix_last;
        w_video_nxt = w_rd_active ? w_pix : '0;
    end

    // Counters, latched select and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_icnt      <= '0;
            r_dcnt      <= '0;
            r_pcnt      <= '0;
            r_bcnt      <= '0;
            r_sel       <= '0;
            r_ad_sp     <= 1'b0;
            r_video     <= '0;
            r_valid     <= 1'b0;
            r_eos       <= 1'b0;
            r_integ_cnt <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ad_sp <= w_ad_sp_nxt;
            r_valid <= w_valid_nxt;
            r_eos   <= w_eos_nxt;
            r_video <= w_video_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (reset_in) r_icnt <= 32'd1;
                end
                c_ST_INTEG: begin
                    if (reset_in) begin
                        if (r_icnt != '1) r_icnt <= r_icnt + 32'd1;
                    end else begin
                        r_integ_cnt <= r_icnt;
                        r_dcnt      <= '0;
                    end
                end
                c_ST_DELAY: begin
                    if (reset_in) begin
                        r_icnt <= 32'd1;
                    end else if (w_dly_done) begin
                        r_sel  <= pattern_sel;
                        r_pcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + c_DCNT_W'(1);
                    end
                end
                c_ST_READOUT: begin
                    if (reset_in) begin
                        r_icnt <= 32'd1;
                    end else begin
                        r_pcnt <= r_pcnt + c_PCNT_W'(1);
                        if (w_pix_last) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_bcnt      <= '0;
                        end
                    end
                end
                c_ST_BLANK: begin
                    if (reset_in) begin
                        r_icnt <= 32'd1;
                    end else if (!w_blk_done) begin
                        r_bcnt <= r_bcnt + c_BCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ad_sp_o       = r_ad_sp;
    assign video_o       = r_video;
    assign video_valid_o = r_valid;
    assign eos_o         = r_eos;
    assign integ_cnt_o   = r_integ_cnt;
    assign frame_cnt_o   = r_frame_cnt;
    assign busy_o        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_g11620_sensor_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_g11620_sensor_emu
//  Description : Self-checking bench for g11620_sensor_emu. Expected pixels
//                are queued per frame from a reference pattern model; a
//                monitor pops and compares every valid video cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_g11620_sensor_emu;

    localparam int PIX = 511;
    localparam int DW  = 10;
    localparam int SPD = 4;
    localparam int BLK = 24;
    localparam int SH  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reset_in;
    logic [1:0]    pattern_sel;
    logic          ad_sp_o;
    logic [DW-1:0] video_o;
    logic          video_valid_o;
    logic          eos_o;
    logic [31:0]   integ_cnt_o;
    logic [15:0]   frame_cnt_o;
    logic          busy_o;

    typedef struct packed {
        logic [DW-1:0] video;
        logic          eos;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              pix_seen = 0;
    longint unsigned exp_integ = 0;
    logic [15:0]     exp_frames = '0;

    always #5 clk = ~clk;

    g11620_sensor_emu #(
        .PIX_NUM     (PIX),
        .DATA_W      (DW),
        .SP_DELAY    (SPD),
        .BLANK_CYC   (BLK),
        .INTEG_SHIFT (SH)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reset_in      (reset_in),
        .pattern_sel   (pattern_sel),
        .ad_sp_o       (ad_sp_o),
        .video_o       (video_o),
        .video_valid_o (video_valid_o),
        .eos_o         (eos_o),
        .integ_cnt_o   (integ_cnt_o),
        .frame_cnt_o   (frame_cnt_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference pixel value straight from the pattern definitions
    function automatic logic [DW-1:0] ref_pix(input int pat, input longint unsigned integ, input int idx);
        longint unsigned mx  = (64'd1 << DW) - 64'd1;
        longint unsigned lvl = integ >> SH;
        longint unsigned v;
        case (pat)
            0:       v = longint'(idx) & mx;
            1:       v = (lvl > mx) ? mx : lvl;
            2:       v = ((lvl + longint'(idx)) > mx) ? mx : (lvl + longint'(idx));
            default: v = (idx % 2 == 1) ? mx : 64'd0;
        endcase
        return v[DW-1:0];
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (video_valid_o) begin
                    pix_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", video_valid_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("video", video_o, e.video);
                        chk("eos", eos_o, e.eos);
                    end
                end else begin
                    chk("eos_idle", eos_o, 0);
                    chk("video_idle", video_o, 0);
                end
            end
        end
    endtask

    task automatic check_reset();
        chk("rst_ad_sp", ad_sp_o, 0);
        chk("rst_valid", video_valid_o, 0);
        chk("rst_eos", eos_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_video", video_o, 0);
        chk("rst_integ_cnt", integ_cnt_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy_o) chk("idle_timeout", busy_o, 0);
    endtask

    // reset_in high for n sampled edges, then low
    task automatic integ_run(input int n);
        reset_in = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset_in = 1'b0;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1 reset_in = 1'b0;
    endtask

    // Entered just after reset_in has been driven low following n high samples
    task automatic readout(input int n, input int pat, input int abort_pix,
                           input int blank_abort, input int rst_pix);
        int k;
        bit busy_ok;
        pattern_sel = 2'(pat);
        exp_q.delete();
        for (int i = 0; i <= PIX; i++) exp_q.push_back('{video: ref_pix(pat, n, i), eos: (i == PIX)});
        @(posedge clk); #1;
        exp_integ = longint'(n);
        chk("integ_cnt", integ_cnt_o, exp_integ);
        k = 0;
        while (!ad_sp_o && k < 4 * SPD + 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ad_sp_delay", k, SPD);
        pix_seen = 0;
        pattern_sel = 2'($urandom);
        @(posedge clk); #1;
        chk("ad_sp_width", ad_sp_o, 0);
        if (rst_pix > 0) begin
            repeat (rst_pix - 1) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk); #1;
            check_reset();
            rst_n = 1'b1;
            exp_q.delete();
            exp_frames = '0;
            exp_integ  = 0;
            return;
        end
        if (abort_pix > 0) begin
            repeat (abort_pix - 1) @(posedge clk);
            #1 reset_in = 1'b1;
            @(posedge clk); #1;
            chk("abort_valid", video_valid_o, 0);
            chk("abort_eos", eos_o, 0);
            chk("abort_busy", busy_o, 1);
            chk("abort_frame_cnt", frame_cnt_o, exp_frames);
            chk("abort_integ_cnt", integ_cnt_o, exp_integ);
            chk("abort_pixels", pix_seen, abort_pix);
            chk("abort_left", exp_q.size(), PIX + 1 - abort_pix);
            exp_q.delete();
            return;
        end
        repeat (PIX) @(posedge clk);
        #1;
        chk("eos_last_pixel", eos_o, 1);
        exp_frames = exp_frames + 16'd1;
        chk("frame_cnt", frame_cnt_o, exp_frames);
        @(posedge clk); #1;
        chk("valid_after_frame", video_valid_o, 0);
        chk("frame_pixels", pix_seen, PIX + 1);
        chk("frame_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        if (blank_abort > 0) begin
            busy_ok = busy_o;
            repeat (blank_abort - 1) begin
                @(posedge clk); #1;
                busy_ok &= busy_o;
            end
            reset_in = 1'b1;
            @(posedge clk); #1;
            busy_ok &= busy_o;
            chk("blank_busy", busy_ok, 1);
            chk("blank_abort_frame_cnt", frame_cnt_o, exp_frames);
        end
    endtask

    task automatic run(input int n, input int pat);
        wait_idle();
        integ_run(n);
        readout(n, pat, -1, -1, -1);
    endtask

    initial begin
        rst_n       = 1'b0;
        reset_in    = 1'b0;
        pattern_sel = 2'd0;
        fork
            monitor();
            begin
                #5000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        run(100, 0);
        run(1000, 1);
        run(1000, 2);
        run(1, 0);
        run(12000, 2);
        run(16384, 2);
        run(37, 3);

        // Abort at pixel 200, then a fresh 50-cycle integration
        wait_idle();
        integ_run(300);
        readout(300, int'($urandom_range(0, 3)), 200, -1, -1);
        hold(49);
        readout(50, 0, -1, -1, -1);

        // New integration started in blank cycle 10
        wait_idle();
        integ_run(80);
        readout(80, 1, -1, 10, -1);
        hold(59);
        readout(60, 2, -1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            run(int'($urandom_range(1, 400)), int'($urandom_range(0, 3)));
        end

        // rst_n pulse in the middle of readout, then recovery
        wait_idle();
        integ_run(100);
        readout(100, 0, -1, -1, 150);
        run(7, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
